up_core_8bit: RTL and testbench

//  8-bit accumulator microprocessor with 256-byte unified code/data RAM and one interrupt input.
//  A host loads and inspects RAM through a memory-map port, then soft-resets the core to run.

---
 rtl/up_core_pkg.sv | 38 +++
 rtl/up_alu.sv | 31 +++
 rtl/up_core_8bit.sv | 146 ++++++++++++++
 tb/tb_up_core_8bit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_core_pkg.sv
// Shared encodings for the 8-bit accumulator core: opcodes, FSM states, ALU ops, core register set.
package up_core_pkg;

    localparam logic [7:0] VECTOR_DEFAULT = 8'hF0;
    localparam logic [8:0] CTRL_ADDR      = 9'h100;

    localparam logic [7:0] OP_NOP  = 8'h00, OP_LDI = 8'h01, OP_LD  = 8'h02, OP_ST  = 8'h03,
                           OP_ADD  = 8'h04, OP_SUB = 8'h05, OP_AND = 8'h06, OP_OR  = 8'h07,
                           OP_XOR  = 8'h08, OP_JMP = 8'h09, OP_JZ  = 8'h0A, OP_JNZ = 8'h0B,
                           OP_JC   = 8'h0C, OP_EI  = 8'h0D, OP_DI  = 8'h0E, OP_RETI = 8'h0F,
                           OP_HALT = 8'h10;

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_OPER = 2'd1, S_EXEC = 2'd2} state_t;

    typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;

    // Everything cleared by nRst and by a host soft reset; RAM lives outside this set.
    typedef struct packed {
        state_t     state;
        logic [7:0] pc;
        logic [7:0] a;
        logic [7:0] ir;
        logic [7:0] opr;
        logic       z;
        logic       c;
        logic       ie;
        logic       pending;
        logic       halted;
        logic       irq_prev;
        logic [7:0] sh_pc;
        logic [7:0] sh_a;
        logic       sh_z;
        logic       sh_c;
    } core_t;

    localparam core_t CORE_RST = '0;

endpackage

// File: rtl/up_alu.sv
// Combinational ALU: accumulator and operand in, result plus Z/C out.
module up_alu
    import up_core_pkg::*;
(
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] result,
    output logic       z,
    output logic       c
);
    logic [8:0] wide;

    // Bit 8 of the subtract is the borrow, so C means "a < b" after SUB.
    always_comb begin
        wide = {1'b0, b};
        c    = c_in;
        case (op)
            ALU_ADD: begin wide = {1'b0, a} + {1'b0, b}; c = wide[8]; end
            ALU_SUB: begin wide = {1'b0, a} - {1'b0, b}; c = wide[8]; end
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: ;
        endcase
        result = wide[7:0];
        z      = (wide[7:0] == 8'd0);
    end

endmodule

// File: rtl/up_core_8bit.sv
// 8-bit accumulator CPU with 256-byte unified RAM, host load/inspect port and one edge interrupt.
// irq is the interrupt request input (rising edge requests service).
module up_core_8bit
    import up_core_pkg::*;
#(
    parameter logic [7:0] VECTOR = VECTOR_DEFAULT
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       irq,
    input  logic       mem_map_load,
    input  logic [8:0] mem_map_address,
    input  logic [7:0] mem_map_in,
    output logic [7:0] mem_map_out
);
    logic [7:0] mem [0:255];
    core_t      r;

    logic [7:0] operand, alu_res, pc_nxt, a_nxt;
    logic       alu_z, alu_c, z_nxt, c_nxt, ie_nxt, halt_nxt, st_en, take;
    alu_op_t    alu_op;

    assign operand = (r.ir == OP_LDI) ? r.opr : mem[r.opr];
    assign take    = r.ie & r.pending;
    assign st_en   = (r.state == S_EXEC) && (r.ir == OP_ST);

    up_alu u_alu (
        .op     (alu_op),
        .a      (r.a),
        .b      (operand),
        .c_in   (r.c),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_comb begin
        alu_op   = ALU_PASS;
        pc_nxt   = r.pc + 8'd2;
        a_nxt    = r.a;
        z_nxt    = r.z;
        c_nxt    = r.c;
        ie_nxt   = r.ie;
        halt_nxt = 1'b0;
        case (r.ir)
            OP_ADD: alu_op = ALU_ADD;
            OP_SUB: alu_op = ALU_SUB;
            OP_AND: alu_op = ALU_AND;
            OP_OR:  alu_op = ALU_OR;
            OP_XOR: alu_op = ALU_XOR;
            default: ;
        endcase
        case (r.ir)
            OP_NOP: ;
            OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                a_nxt = alu_res;
                z_nxt = alu_z;
                c_nxt = alu_c;
            end
            OP_JMP:  pc_nxt = r.opr;
            OP_JZ:   if (r.z)  pc_nxt = r.opr;
            OP_JNZ:  if (!r.z) pc_nxt = r.opr;
            OP_JC:   if (r.c)  pc_nxt = r.opr;
            OP_EI:   ie_nxt = 1'b1;
            OP_DI:   ie_nxt = 1'b0;
            OP_RETI: begin
                pc_nxt = r.sh_pc;
                a_nxt  = r.sh_a;
                z_nxt  = r.sh_z;
                c_nxt  = r.sh_c;
                ie_nxt = 1'b1;
            end
            OP_HALT: halt_nxt = 1'b1;
            default: ;
        endcase
    end

    // Host load stalls the whole core; only the control address has an effect on it.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r <= CORE_RST;
        end else if (mem_map_load) begin
            if (mem_map_address == CTRL_ADDR) r <= CORE_RST;
        end else begin
            r.irq_prev <= irq;
            if (irq && !r.irq_prev) r.pending <= 1'b1;
            case (r.state)
                S_FETCH: begin
                    if (!r.halted) begin
                        r.ir    <= mem[r.pc];
                        r.state <= S_OPER;
                    end else if (take) begin
                        r.sh_pc   <= r.pc;
                        r.sh_a    <= r.a;
                        r.sh_z    <= r.z;
                        r.sh_c    <= r.c;
                        r.pc      <= VECTOR;
                        r.ie      <= 1'b0;
                        r.pending <= 1'b0;
                        r.halted  <= 1'b0;
                    end
                end
                S_OPER: begin
                    r.opr   <= mem[r.pc + 8'd1];
                    r.state <= S_EXEC;
                end
                S_EXEC: begin
                    r.state <= S_FETCH;
                    r.a     <= a_nxt;
                    r.z     <= z_nxt;
                    r.c     <= c_nxt;
                    if (take) begin
                        r.sh_pc   <= pc_nxt;
                        r.sh_a    <= a_nxt;
                        r.sh_z    <= z_nxt;
                        r.sh_c    <= c_nxt;
                        r.pc      <= VECTOR;
                        r.ie      <= 1'b0;
                        r.pending <= 1'b0;
                        r.halted  <= 1'b0;
                    end else begin
                        r.pc     <= pc_nxt;
                        r.ie     <= ie_nxt;
                        r.halted <= halt_nxt;
                    end
                end
                default: r.state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_map_load) begin
            if (!mem_map_address[8]) mem[mem_map_address[7:0]] <= mem_map_in;
        end else if (st_en) begin
            mem[r.opr] <= r.a;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)                   mem_map_out <= 8'h00;
        else if (mem_map_address[8]) mem_map_out <= r.a;
        else                         mem_map_out <= mem[mem_map_address[7:0]];
    end

endmodule

// File: tb/tb_up_core_8bit.sv
// Bench for up_core_8bit: directed programs plus random straight-line programs checked by an ISA model.
module tb_up_core_8bit;
    logic       clk = 1'b0, nRst = 1'b0, irq = 1'b0, mem_map_load = 1'b0;
    logic [8:0] mem_map_address = 9'h000;
    logic [7:0] mem_map_in = 8'h00;
    logic [7:0] mem_map_out;

    int checks = 0, errors = 0;
    logic [7:0] mm [256];
    logic [7:0] ma;
    logic       mz, mc;

    up_core_8bit dut (
        .clk             (clk),
        .nRst            (nRst),
        .irq             (irq),
        .mem_map_load    (mem_map_load),
        .mem_map_address (mem_map_address),
        .mem_map_in      (mem_map_in),
        .mem_map_out     (mem_map_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        mem_map_load = 1'b1; mem_map_address = {1'b0, addr}; mem_map_in = data;
        mm[addr] = data;
        @(negedge clk);
    endtask

    task automatic poke_prog(input logic [7:0] base, input logic [7:0] q [$]);
        for (int k = 0; k < q.size(); k++) poke(8'(base + k[7:0]), q[k]);
    endtask

    task automatic start_core(input logic [8:0] watch);
        mem_map_load = 1'b1; mem_map_address = 9'h100; mem_map_in = 8'h00;
        @(negedge clk);
        mem_map_load = 1'b0; mem_map_address = watch;
    endtask

    task automatic host_read(input logic [8:0] addr, output logic [7:0] val);
        mem_map_load = 1'b0; mem_map_address = addr;
        @(negedge clk);
        val = mem_map_out;
    endtask

    // Instruction-level reference: runs from PC 0 with cleared registers until HALT.
    task automatic model_run(output int steps);
        logic [7:0] pc, ir, op, v;
        int sum;
        bit done;
        pc = 8'h00; ma = 8'h00; mz = 1'b0; mc = 1'b0; steps = 0; done = 1'b0;
        while (!done && steps < 300) begin
            ir = mm[pc]; op = mm[pc + 8'd1]; v = mm[op];
            steps++;
            pc = pc + 8'd2;
            case (ir)
                8'h01: ma = op;
                8'h02: ma = v;
                8'h03: mm[op] = ma;
                8'h04: begin sum = int'(ma) + int'(v); mc = (sum > 255); ma = 8'(sum); end
                8'h05: begin mc = (ma < v); ma = 8'(int'(ma) - int'(v)); end
                8'h06: ma = ma & v;
                8'h07: ma = ma | v;
                8'h08: ma = ma ^ v;
                8'h09: pc = op;
                8'h0A: if (mz) pc = op;
                8'h0B: if (!mz) pc = op;
                8'h0C: if (mc) pc = op;
                8'h10: done = 1'b1;
                default: ;
            endcase
            if (ir inside {8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}) mz = (ma == 8'h00);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        nRst = 1'b0; mem_map_load = 1'b0;
        tick(2);
        checks++;
        if (mem_map_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", mem_map_out); end
        for (int i = 0; i < 256; i++) poke(i[7:0], 8'h10);
        poke(8'h05, 8'hAA);
        mem_map_load = 1'b0; mem_map_address = 9'h005;
        nRst = 1'b1;
        host_read(9'h005, v);
        checks++;
        if (v !== 8'hAA) begin errors++; $display("FAIL load_read: got %h expected aa", v); end
        host_read(9'h100, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_a: got %h expected 00", v); end
    endtask

    task automatic test_arith();
        logic [7:0] v;
        logic [7:0] q [$];
        q = {8'h01, 8'hFF, 8'h04, 8'h90, 8'h03, 8'h80, 8'h10, 8'h00, 8'h01, 8'h77, 8'h03, 8'h82, 8'h10, 8'h00};
        poke_prog(8'h00, q);
        poke(8'h90, 8'h02); poke(8'h80, 8'h00); poke(8'h82, 8'h00);
        start_core(9'h080);
        tick(9);
        checks++;
        if (mem_map_out !== 8'h00) begin errors++; $display("FAIL st_early: got %h expected 00 after 9 cycles", mem_map_out); end
        tick(1);
        checks++;
        if (mem_map_out !== 8'h01) begin errors++; $display("FAIL st_timing: got %h expected 01 after 10 cycles", mem_map_out); end
        tick(30);
        host_read(9'h082, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL halt_stops: got %h expected 00", v); end
        host_read(9'h100, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL add_wrap_a: got %h expected 01", v); end

        // Carry set, zero clear after FF+02
        q = {8'h01, 8'hFF, 8'h04, 8'h90, 8'h0C, 8'h08, 8'h10, 8'h00,
             8'h0A, 8'h0E, 8'h03, 8'h81, 8'h10, 8'h00, 8'h10, 8'h00};
        poke_prog(8'h00, q);
        poke(8'h81, 8'h00);
        start_core(9'h100);
        tick(40);
        host_read(9'h081, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL add_flags: got %h expected 01", v); end

        // Zero set, borrow clear after 01-01
        q = {8'h01, 8'h01, 8'h05, 8'h91, 8'h0A, 8'h08, 8'h10, 8'h00,
             8'h0C, 8'h10, 8'h01, 8'h5C, 8'h03, 8'h83, 8'h10, 8'h00, 8'h10, 8'h00};
        poke_prog(8'h00, q);
        poke(8'h91, 8'h01); poke(8'h83, 8'h00);
        start_core(9'h100);
        tick(40);
        host_read(9'h083, v);
        checks++;
        if (v !== 8'h5C) begin errors++; $display("FAIL sub_flags: got %h expected 5c", v); end
    endtask

    task automatic test_random_programs();
        logic [7:0] v;
        int steps, n, kind;
        logic [7:0] da;
        logic [7:0] prog [$];
        for (int it = 0; it < 8; it++) begin
            prog = {};
            n = $urandom_range(6, 16);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 11);
                da = 8'(8'h80 + $urandom_range(0, 15));
                if (kind == 0) begin
                    prog.push_back(8'h01); prog.push_back(8'($urandom));
                end else if (kind <= 7) begin
                    prog.push_back(8'(kind + 1)); prog.push_back(da);
                end else if (kind <= 10) begin
                    prog.push_back(8'(8'h0A + kind - 8)); prog.push_back(8'(2 * i + 4));
                end else begin
                    prog.push_back(8'(8'h20 + $urandom_range(0, 31))); prog.push_back(8'($urandom));
                end
            end
            prog.push_back(8'h10); prog.push_back(8'h00);
            prog.push_back(8'h10); prog.push_back(8'h00);
            poke_prog(8'h00, prog);
            for (int d = 0; d < 16; d++) poke(8'(8'h80 + d), 8'($urandom));
            model_run(steps);
            start_core(9'h100);
            tick(3 * steps + 6);
            for (int d = 0; d < 16; d++) begin
                host_read({1'b0, 8'(8'h80 + d)}, v);
                checks++;
                if (v !== mm[8'(8'h80 + d)]) begin
                    errors++;
                    $display("FAIL rand_mem it=%0d addr=%h: got %h expected %h", it, 8'(8'h80 + d), v, mm[8'(8'h80 + d)]);
                end
            end
            host_read(9'h100, v);
            checks++;
            if (v !== ma) begin errors++; $display("FAIL rand_a it=%0d: got %h expected %h", it, v, ma); end
        end
    endtask

    task automatic test_fibonacci();
        logic [7:0] v;
        logic [7:0] q [$];
        logic [7:0] exp_fib [8];
        exp_fib = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd0};
        q = {8'h01, 8'h01, 8'h03, 8'h70, 8'h03, 8'h71, 8'h03, 8'h73, 8'h01, 8'h07, 8'h03, 8'h72,
             8'h02, 8'h70, 8'h03, 8'h80, 8'h02, 8'h0F, 8'h04, 8'h73, 8'h03, 8'h0F,
             8'h02, 8'h70, 8'h04, 8'h71, 8'h03, 8'h74, 8'h02, 8'h71, 8'h03, 8'h70,
             8'h02, 8'h74, 8'h03, 8'h71, 8'h02, 8'h72, 8'h05, 8'h73, 8'h03, 8'h72,
             8'h0B, 8'h0C, 8'h10, 8'h00};
        poke_prog(8'h00, q);
        for (int d = 0; d < 8; d++) poke(8'(8'h80 + d), 8'h00);
        start_core(9'h100);
        tick(400);
        for (int d = 0; d < 8; d++) begin
            host_read({1'b0, 8'(8'h80 + d)}, v);
            checks++;
            if (v !== exp_fib[d]) begin errors++; $display("FAIL fib[%0d]: got %0d expected %0d", d, v, exp_fib[d]); end
        end
    endtask

    task automatic test_wrap_soft_reset();
        logic [7:0] q [$];
        q = {8'h02, 8'h60, 8'h04, 8'h61, 8'h03, 8'h60, 8'h09, 8'hFE};
        poke_prog(8'h00, q);
        poke(8'hFE, 8'h00); poke(8'hFF, 8'h00);
        poke(8'h60, 8'h00); poke(8'h61, 8'h01);
        start_core(9'h060);
        tick(64);
        checks++;
        if (mem_map_out !== 8'd4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", mem_map_out); end
        mem_map_load = 1'b1; mem_map_address = 9'h100;
        tick(2);
        checks++;
        if (mem_map_out !== 8'h00) begin errors++; $display("FAIL soft_reset_a: got %h expected 00", mem_map_out); end
        mem_map_load = 1'b0; mem_map_address = 9'h060;
        tick(64);
        checks++;
        if (mem_map_out !== 8'd8) begin errors++; $display("FAIL soft_reset_restart: got %0d expected 8", mem_map_out); end
    endtask

    task automatic test_interrupt();
        logic [7:0] v, src;
        logic [7:0] q [$];
        src = 8'($urandom_range(1, 254));
        q = {8'h01, 8'h5A, 8'h0D, 8'h00, 8'h10, 8'h00, 8'h03, 8'hA2, 8'h0E, 8'h00};
        poke_prog(8'h00, q);
        for (int k = 8'h0A; k < 8'h3E; k++) poke(k[7:0], 8'h00);
        q = {8'h09, 8'h50};
        poke_prog(8'h3E, q);
        q = {8'h0D, 8'h00, 8'h01, 8'h77, 8'h03, 8'hA5, 8'h10, 8'h00};
        poke_prog(8'h50, q);
        q = {8'h02, 8'h40, 8'h03, 8'h41, 8'h02, 8'hA3, 8'h04, 8'hA4, 8'h03, 8'hA3, 8'h0F, 8'h00};
        poke_prog(8'hF0, q);
        poke(8'h40, src); poke(8'h41, 8'h00);
        poke(8'hA2, 8'h00); poke(8'hA3, 8'h00); poke(8'hA4, 8'h01); poke(8'hA5, 8'h00);
        start_core(9'h100);
        tick(15);
        host_read(9'h0A3, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL irq_idle: got %0d expected 0", v); end
        irq = 1'b1; tick(3); irq = 1'b0;
        tick(25);
        host_read(9'h041, v);
        checks++;
        if (v !== src) begin errors++; $display("FAIL isr_copy: got %h expected %h", v, src); end
        host_read(9'h0A3, v);
        checks++;
        if (v !== 8'd1) begin errors++; $display("FAIL isr_count1: got %0d expected 1", v); end
        host_read(9'h0A2, v);
        checks++;
        if (v !== 8'h5A) begin errors++; $display("FAIL reti_a: got %h expected 5a", v); end
        irq = 1'b1; tick(3); irq = 1'b0;
        tick(40);
        host_read(9'h0A3, v);
        checks++;
        if (v !== 8'd1) begin errors++; $display("FAIL irq_masked: got %0d expected 1", v); end
        tick(80);
        host_read(9'h0A3, v);
        checks++;
        if (v !== 8'd2) begin errors++; $display("FAIL irq_pending_taken: got %0d expected 2", v); end
        host_read(9'h0A5, v);
        checks++;
        if (v !== 8'h77) begin errors++; $display("FAIL reti_a2: got %h expected 77", v); end
        host_read(9'h100, v);
        checks++;
        if (v !== 8'h77) begin errors++; $display("FAIL final_a: got %h expected 77", v); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_random_programs();
        test_fibonacci();
        test_wrap_soft_reset();
        test_interrupt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
